qpi_line_burst: RTL and testbench

Upstream master for the QPI-to-SDRAM Wishbone adapter. Converts one cache-line fill or writeback request into a burst of word accesses on the qpi_* interface (qpi_do_read/qpi_do_write, qpi_addr, qpi_wdata, qpi_rdata, qpi_next_word, qpi_is_idle). It advances the address and data index per word and signals completion to the cache controller. Sits between the cache tag/control FSM and the adapter.

---
 rtl/qpi_line_burst.sv | 143 ++++++++++++++
 tb/tb_qpi_line_burst.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpi_line_burst.sv
// qpi_line_burst: turns one cache-line fill or writeback request into a
// burst of word accesses on the qpi_* adapter interface.
//
// Optional feature macro: QPI_CRITICAL_WORD_FIRST_EN
//   defined   - fills start at req_addr's word and wrap within the line
//   undefined - every burst starts at word 0 of the line
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*           line request handshake from the cache controller
//   wr_idx/wr_data  writeback word index out, cache word in (combinational)
//   rd_*            fill word strobe, index and data back to the cache
//   busy, done      transfer in progress / one-cycle completion pulse
//   qpi_*           word-access interface to the QPI adapter
module qpi_line_burst #(
   parameter int  LINE_WORDS = 8,
   parameter int  AW         = 25,
   localparam int CW         = $clog2(LINE_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   output logic          req_ready,
   output logic [CW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   output logic          rd_valid,
   output logic [CW-1:0] rd_idx,
   output logic [31:0]   rd_data,
   output logic          busy,
   output logic          done,
   output logic          qpi_do_read,
   output logic          qpi_do_write,
   output logic [AW-1:0] qpi_addr,
   output logic [31:0]   qpi_wdata,
   input  logic [31:0]   qpi_rdata,
   input  logic          qpi_next_word,
   input  logic          qpi_is_idle
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic          we_r;
   logic [AW-1:0] base_r;
   logic [CW-1:0] start_r;
   logic [CW:0]   cnt;

   logic [CW-1:0] cur_idx;
   logic [CW-1:0] idx;
   logic          last;
   logic          accept;
   logic          word_ack;

   // Index of the word currently in flight.
   assign cur_idx = start_r + cnt[CW-1:0];

   // The adapter latches address/data for the following word in the same
   // cycle it acks the current one, so the index looks one word ahead on
   // next_word. CW-bit addition gives the wrap within the line.
   assign idx = cur_idx + CW'(qpi_next_word);

   assign last = (cnt == (CW+1)'(LINE_WORDS-1)) && qpi_next_word;

   assign accept   = (state == ST_IDLE) && req_valid && qpi_is_idle;
   assign word_ack = (state == ST_XFER) && qpi_next_word;

   assign qpi_wdata = wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         we_r     <= 1'b0;
         base_r   <= '0;
         start_r  <= '0;
         rd_valid <= 1'b0;
         rd_idx   <= '0;
         rd_data  <= '0;
      end else begin
         state    <= state_nx;
         rd_valid <= 1'b0;
         if (accept) begin
            we_r   <= req_we;
            base_r <= req_addr & ~AW'(LINE_WORDS-1);
            cnt    <= '0;
`ifdef QPI_CRITICAL_WORD_FIRST_EN
            start_r <= req_we ? '0 : req_addr[CW-1:0];
`else
            start_r <= '0;
`endif
         end
         if (word_ack) begin
            cnt <= cnt + 1'b1;
            if (!we_r) begin
               rd_valid <= 1'b1;
               rd_data  <= qpi_rdata;
               rd_idx   <= cur_idx;
            end
         end
      end
   end

   always_comb begin
      state_nx     = state;
      req_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      qpi_do_read  = 1'b0;
      qpi_do_write = 1'b0;
      qpi_addr     = '0;
      wr_idx       = '0;
      unique case (state)
         ST_IDLE: begin
            req_ready = qpi_is_idle;
            if (accept) state_nx = ST_XFER;
         end
         ST_XFER: begin
            busy = 1'b1;
            // Drop the request with the final ack so the adapter does not
            // start one access past the end of the line.
            qpi_do_read  = !we_r && !last;
            qpi_do_write = we_r && !last;
            qpi_addr     = base_r | AW'(idx);
            wr_idx       = idx;
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_qpi_line_burst.sv
// tb_qpi_line_burst: randomized self-checking bench for qpi_line_burst.
// The bench plays both the cache and the QPI adapter.
module tb_qpi_line_burst;

   localparam int LW = 8;
   localparam int AW = 25;
   localparam int CW = $clog2(LW);

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic [CW-1:0] wr_idx;
   logic [31:0]   wr_data;
   logic          rd_valid;
   logic [CW-1:0] rd_idx;
   logic [31:0]   rd_data;
   logic          busy;
   logic          done;
   logic          qpi_do_read;
   logic          qpi_do_write;
   logic [AW-1:0] qpi_addr;
   logic [31:0]   qpi_wdata;
   logic [31:0]   qpi_rdata;
   logic          qpi_next_word;
   logic          qpi_is_idle;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0]   wsalt = 0;
   logic [31:0]   rsalt = 0;

   logic [AW-1:0] obs_addr[$];
   logic [31:0]   obs_wdata[$];
   logic          obs_we[$];
   logic [CW-1:0] rdi_q[$];
   logic [31:0]   rdd_q[$];
   int            done_cnt;
   int            done_rd;
   int            viol = 0;

   logic [AW-1:0] exp_addr[$];
   logic [CW-1:0] exp_idx[$];

   qpi_line_burst #(.LINE_WORDS(LW), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_idx       (rd_idx),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .qpi_do_read  (qpi_do_read),
      .qpi_do_write (qpi_do_write),
      .qpi_addr     (qpi_addr),
      .qpi_wdata    (qpi_wdata),
      .qpi_rdata    (qpi_rdata),
      .qpi_next_word(qpi_next_word),
      .qpi_is_idle  (qpi_is_idle)
   );

   // Cache model: writeback word k of the line is 0xA0000000 + k + salt.
   assign wr_data = 32'hA000_0000 + 32'(wr_idx) + wsalt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rdata_of(input logic [AW-1:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ rsalt;
   endfunction

   // Monitor of the cache-side outputs, sampled 1 time unit after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst === 1'b0) begin
            if (rd_valid === 1'b1) begin
               rdi_q.push_back(rd_idx);
               rdd_q.push_back(rd_data);
            end
            if (done === 1'b1) begin
               done_cnt++;
               if (rd_valid === 1'b1) done_rd++;
            end
            if (req_ready === 1'b1 && busy === 1'b1) viol++;
         end
      end
   end

   // Reference: line words in fetch order, from the line base and the
   // starting word.
   task automatic build_exp(input bit we, input logic [AW-1:0] a);
      int ai;
      int start;
      int ix;
      logic [AW-1:0] base;
      exp_addr.delete();
      exp_idx.delete();
      ai    = int'(a);
      base  = AW'(ai - (ai % LW));
      start = 0;
`ifdef QPI_CRITICAL_WORD_FIRST_EN
      if (!we) start = ai % LW;
`endif
      for (int k = 0; k < LW; k++) begin
         ix = (start + k) % LW;
         exp_idx.push_back(CW'(ix));
         exp_addr.push_back(base + AW'(ix));
      end
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_wdata.delete();
      obs_we.delete();
      rdi_q.delete();
      rdd_q.delete();
      done_cnt = 0;
      done_rd  = 0;
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic issue_req(input bit we, input logic [AW-1:0] a,
                            output bit to);
      int n;
      n = 0;
      clear_obs();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      #1;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      to = (n >= 50);
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
   endtask

   // Adapter model: latch address/data when an access starts, ack after
   // 1+stall cycles, and latch the next word in the ack cycle if the
   // request is still up. Returns at the negedge after the last ack.
   task automatic serve(input int max_stall, input int abort_after,
                        output bit to);
      int words;
      bit more;
      logic [AW-1:0] cur;
      words = 0;
      to    = 1'b0;
      #1;
      more = qpi_do_read || qpi_do_write;
      cur  = qpi_addr;
      if (more) begin
         obs_addr.push_back(qpi_addr);
         obs_wdata.push_back(qpi_wdata);
         obs_we.push_back(qpi_do_write);
      end
      while (more && !to) begin
         repeat (1 + $urandom_range(0, max_stall)) @(negedge clk);
         qpi_next_word = 1'b1;
         qpi_rdata     = rdata_of(cur);
         #1;
         words++;
         more = qpi_do_read || qpi_do_write;
         if (more) begin
            cur = qpi_addr;
            obs_addr.push_back(qpi_addr);
            obs_wdata.push_back(qpi_wdata);
            obs_we.push_back(qpi_do_write);
         end
         @(negedge clk);
         qpi_next_word = 1'b0;
         qpi_rdata     = 32'($urandom);
         if (abort_after != 0 && words == abort_after) return;
         if (words > 2 * LW) to = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      req_valid     = 1'b0;
      req_we        = 1'b0;
      req_addr      = '0;
      qpi_rdata     = '0;
      qpi_next_word = 1'b0;
      qpi_is_idle   = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({req_ready, busy, done, rd_valid, qpi_do_read, qpi_do_write}
          !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 100000",
                  {req_ready, busy, done, rd_valid,
                   qpi_do_read, qpi_do_write});
      end
      n_tests++;
      if (qpi_addr !== '0 || wr_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h/%h want 0/0", qpi_addr, wr_idx);
      end
      rst = 1'b0;
      qpi_is_idle = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_gate: got %b want 0", req_ready);
      end
      qpi_is_idle = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_burst(input string nm, input bit we,
                             input logic [AW-1:0] a, input int stall,
                             input logic [31:0] ws);
      bit to1;
      bit to2;
      logic [31:0] ewd;
      wsalt = ws;
      rsalt = $urandom;
      build_exp(we, a);
      issue_req(we, a, to1);
      serve(stall, 0, to2);
      n_tests++;
      if (to1 || to2) begin
         n_fail++;
         $display("FAIL %s timeout: got %b%b want 00", nm, to1, to2);
      end
      n_tests++;
      if (obs_addr.size() != LW) begin
         n_fail++;
         $display("FAIL %s acc_count: got %0d want %0d",
                  nm, obs_addr.size(), LW);
      end
      for (int k = 0; k < LW && k < obs_addr.size(); k++) begin
         ewd = 32'hA000_0000 + 32'(exp_idx[k]) + ws;
         n_tests++;
         if (obs_addr[k] !== exp_addr[k] || obs_we[k] !== we ||
             (we && obs_wdata[k] !== ewd)) begin
            n_fail++;
            $display("FAIL %s acc[%0d]: got %h/%b/%h want %h/%b/%h",
                     nm, k, obs_addr[k], obs_we[k], obs_wdata[k],
                     exp_addr[k], we, ewd);
         end
      end
      n_tests++;
      if (rdi_q.size() != (we ? 0 : LW)) begin
         n_fail++;
         $display("FAIL %s rd_count: got %0d want %0d",
                  nm, rdi_q.size(), we ? 0 : LW);
      end
      if (!we) begin
         for (int k = 0; k < LW && k < rdi_q.size(); k++) begin
            n_tests++;
            if (rdi_q[k] !== exp_idx[k] ||
                rdd_q[k] !== rdata_of(exp_addr[k])) begin
               n_fail++;
               $display("FAIL %s rd[%0d]: got %0d/%h want %0d/%h",
                        nm, k, rdi_q[k], rdd_q[k],
                        exp_idx[k], rdata_of(exp_addr[k]));
            end
         end
      end
      n_tests++;
      if (done_cnt != 1 || done_rd != (we ? 0 : 1)) begin
         n_fail++;
         $display("FAIL %s done: got %0d/%0d want 1/%0d",
                  nm, done_cnt, done_rd, we ? 0 : 1);
      end
      @(negedge clk);
   endtask

   task automatic test_random_stall();
      for (int i = 0; i < 5; i++)
         test_burst("rand", 1'($urandom), AW'($urandom), 5, $urandom);
   endtask

   task automatic test_critical_word();
      logic [AW-1:0] want0;
`ifdef QPI_CRITICAL_WORD_FIRST_EN
      want0 = 25'h105;
`else
      want0 = 25'h100;
`endif
      test_burst("cwf", 1'b0, 25'h105, 0, 0);
      n_tests++;
      if (obs_addr.size() == 0 || obs_addr[0] !== want0) begin
         n_fail++;
         $display("FAIL cwf_first: got %h want %h",
                  obs_addr.size() ? obs_addr[0] : 'x, want0);
      end
   endtask

   task automatic test_back_to_back();
      bit to1;
      bit to2;
      logic [AW-1:0] a2;
      a2 = AW'($urandom);
      wsalt = $urandom;
      issue_req(1'b1, AW'($urandom), to1);
      serve(0, 0, to2);
      n_tests++;
      if (to1 || to2 || obs_addr.size() != LW || done !== 1'b1 ||
          req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: got %b%b/%0d/%b/%b want 00/%0d/1/0",
                  to1, to2, obs_addr.size(), done, req_ready, LW);
      end
      build_exp(1'b0, a2);
      clear_obs();
      qpi_is_idle = 1'b0;
      req_valid   = 1'b1;
      req_we      = 1'b0;
      req_addr    = a2;
      @(negedge clk);
      #1;
      n_tests++;
      if ({req_ready, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_held: got %b want 00", {req_ready, busy});
      end
      qpi_is_idle = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready: got %b want 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      serve(1, 0, to2);
      n_tests++;
      if (to2 || obs_addr.size() != LW || done_cnt != 1) begin
         n_fail++;
         $display("FAIL b2b_second: got %b/%0d/%0d want 0/%0d/1",
                  to2, obs_addr.size(), done_cnt, LW);
      end
      for (int k = 0; k < LW && k < obs_addr.size(); k++) begin
         n_tests++;
         if (obs_addr[k] !== exp_addr[k]) begin
            n_fail++;
            $display("FAIL b2b_addr[%0d]: got %h want %h",
                     k, obs_addr[k], exp_addr[k]);
         end
      end
      n_tests++;
      if (viol != 0) begin
         n_fail++;
         $display("FAIL ready_while_busy: got %0d want 0", viol);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit to1;
      bit to2;
      issue_req(1'b0, 25'h100, to1);
      serve(2, 3, to2);
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_tests++;
      if ({qpi_do_read, busy, done, rd_valid} !== 4'b0000 || to1) begin
         n_fail++;
         $display("FAIL reset_mid: got %b/%b want 0000/0",
                  {qpi_do_read, busy, done, rd_valid}, to1);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (done_cnt != 0 || rdi_q.size() != 3) begin
         n_fail++;
         $display("FAIL reset_mid_obs: got %0d/%0d want 0/3",
                  done_cnt, rdi_q.size());
      end
      test_burst("after_reset", 1'b0, AW'($urandom), 2, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_burst("fill", 1'b0, 25'h000100, 0, 0);
      test_burst("writeback", 1'b1, 25'h0001F8, 0, 0);
      test_random_stall();
      test_critical_word();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
